stg4ma: RTL

- Pipeline stage 4: memory access. Sits between stg3ex and the writeback stage.
- Consumes the latched stg3ex outputs (pc, instr, opc, tgt_gp, tgt_sr, result) plus a store-data operand.
- Performs loads/stores over a req/ack data-memory port, stalling upstream until ack; all other ops pass straight through.
- Presents one registered bundle per cycle to writeback.

---
 rtl/stg4ma_pkg.sv | 37 +++
 rtl/stg4ma_bus.sv | 121 ++++++++++++
 rtl/stg4ma.sv | 97 +++++++++
 3 files changed

// File: rtl/stg4ma_pkg.sv
// Shared sizes, opcodes, memory-access FSM codes and the writeback bundle
// used by the memory-access stage (stg4ma) and its bus controller.
package stg4ma_pkg;

    localparam int SIZE_ADDR   = 24;
    localparam int SIZE_DATA   = 24;
    localparam int SIZE_OPC    = 6;
    localparam int SIZE_TGT_GP = 4;
    localparam int SIZE_TGT_SR = 2;
    localparam int HBIT_ADDR   = SIZE_ADDR - 1;

    localparam logic [SIZE_OPC-1:0] OPC_NOP  = 6'h00;
    localparam logic [SIZE_OPC-1:0] OPC_ADD  = 6'h01;
    localparam logic [SIZE_OPC-1:0] OPC_M_LD = 6'h10;
    localparam logic [SIZE_OPC-1:0] OPC_M_ST = 6'h11;

    localparam int SIZE_MA_STATE = 1;

    typedef enum logic [SIZE_MA_STATE-1:0] {
        MA_STATE_IDLE = 1'b0,
        MA_STATE_BUSY = 1'b1
    } ma_state_e;

    typedef struct packed {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_DATA-1:0]   instr;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] tgt_gp;
        logic [SIZE_TGT_SR-1:0] tgt_sr;
        logic [SIZE_DATA-1:0]   result;
    } ma_wb_t;

    function automatic logic is_mem_op(input logic [SIZE_OPC-1:0] opc);
        return (opc == OPC_M_LD) || (opc == OPC_M_ST);
    endfunction

endpackage

// File: rtl/stg4ma_bus.sv
// Data-memory req/ack controller for stg4ma: FSM, latched request fields
// and, with STG4MA_TIMEOUT_EN defined, the wait counter and fault pulse.
module stg4ma_bus
    import stg4ma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 start_we,
    input  logic [SIZE_ADDR-1:0] start_addr,
    input  logic [SIZE_DATA-1:0] start_wdata,
    input  logic                 ack,
    output logic                 req,
    output logic                 we,
    output logic [SIZE_ADDR-1:0] addr,
    output logic [SIZE_DATA-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 expire,
    output logic                 fault
);

    ma_state_e            state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [SIZE_ADDR-1:0] addr_q, addr_d;
    logic [SIZE_DATA-1:0] wdata_q, wdata_d;

    assign busy = (state_q == MA_STATE_BUSY);
    assign done = busy && (ack || expire);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            MA_STATE_IDLE: begin
                if (start) begin
                    state_d = MA_STATE_BUSY;
                    req_d   = 1'b1;
                    we_d    = start_we;
                    addr_d  = start_addr;
                    wdata_d = start_wdata;
                end
            end
            MA_STATE_BUSY: begin
                if (ack || expire) begin
                    state_d = MA_STATE_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = MA_STATE_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MA_STATE_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign req   = req_q;
    assign we    = we_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

`ifdef STG4MA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    // An ack arriving in the expiry cycle takes priority over the abort.
    assign expire = busy && !ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d   = cnt_q;
        fault_d = expire;
        if (!busy) begin
            cnt_d = '0;
        end else if (!ack && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign expire = 1'b0;
    assign fault  = 1'b0;
`endif

endmodule

// File: rtl/stg4ma.sv
// Pipeline stage 4, memory access: stall logic and writeback bundle register.
// Optional access timeout enabled by defining STG4MA_TIMEOUT_EN.
module stg4ma
    import stg4ma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic [SIZE_ADDR-1:0]   iw_pc,
    input  logic [SIZE_DATA-1:0]   iw_instr,
    input  logic [SIZE_OPC-1:0]    iw_opc,
    input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic [SIZE_DATA-1:0]   iw_result,
    input  logic [SIZE_DATA-1:0]   iw_st_data,
    output logic                   ow_stall,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic [SIZE_ADDR-1:0]   ow_mem_addr,
    output logic [SIZE_DATA-1:0]   ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [SIZE_DATA-1:0]   iw_mem_rdata,
    output logic [SIZE_ADDR-1:0]   ow_pc,
    output logic [SIZE_DATA-1:0]   ow_instr,
    output logic [SIZE_OPC-1:0]    ow_opc,
    output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic [SIZE_DATA-1:0]   ow_result,
    output logic                   ow_fault
);

    logic   start;
    logic   busy;
    logic   done;
    logic   expire;
    ma_wb_t wb_q, wb_d;

    assign start = !busy && is_mem_op(iw_opc);

    stg4ma_bus #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus (
        .clk        (iw_clk),
        .rst        (iw_rst),
        .start      (start),
        .start_we   (iw_opc == OPC_M_ST),
        .start_addr (iw_result[HBIT_ADDR:0]),
        .start_wdata(iw_st_data),
        .ack        (iw_mem_ack),
        .req        (ow_mem_req),
        .we         (ow_mem_we),
        .addr       (ow_mem_addr),
        .wdata      (ow_mem_wdata),
        .busy       (busy),
        .done       (done),
        .expire     (expire),
        .fault      (ow_fault)
    );

    assign ow_stall = start || (busy && !done);

    // Stall cycles register a bubble; everything else loads the inputs.
    always_comb begin
        wb_d = '0;
        if (!ow_stall) begin
            wb_d.pc     = iw_pc;
            wb_d.instr  = iw_instr;
            wb_d.opc    = iw_opc;
            wb_d.tgt_gp = iw_tgt_gp;
            wb_d.tgt_sr = iw_tgt_sr;
            wb_d.result = iw_result;
            if (done && expire) begin
                wb_d.result = '0;
                wb_d.tgt_gp = '0;
            end else if (done && iw_opc == OPC_M_LD) begin
                wb_d.result = iw_mem_rdata;
            end
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign ow_pc     = wb_q.pc;
    assign ow_instr  = wb_q.instr;
    assign ow_opc    = wb_q.opc;
    assign ow_tgt_gp = wb_q.tgt_gp;
    assign ow_tgt_sr = wb_q.tgt_sr;
    assign ow_result = wb_q.result;

endmodule
